crosswalk_sequencer: RTL and testbench

//  Phase controller for one signalised mid-block crossing. Sequences vehicle lamps
//  (green/yellow/red) and the pedestrian phase on demand from a push button.

---
 rtl/crosswalk_pkg.sv | 16 +
 rtl/phase_timer.sv | 39 +++
 rtl/crosswalk_sequencer.sv | 138 +++++++++++++
 tb/tb_crosswalk_sequencer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/crosswalk_pkg.sv
// rtl/crosswalk_pkg.sv - shared types and constants for the crosswalk sequencer
package crosswalk_pkg;

   localparam int TIMER_W = 7;
   localparam logic [TIMER_W-1:0] BLANK_TIMER = 7'd127;

   typedef enum logic [2:0] {
      ST_GREEN   = 3'd0,
      ST_YELLOW  = 3'd1,
      ST_RED_IN  = 3'd2,
      ST_WALK    = 3'd3,
      ST_CLEAR   = 3'd4,
      ST_RED_OUT = 3'd5
   } state_t;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - tick-driven phase down-counter with load, saturation and expire strobe
module phase_timer
   import crosswalk_pkg::*;
#(
   parameter logic [TIMER_W-1:0] RESET_VALUE = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_value,
   input  logic               tick,
   input  logic               saturate,
   output logic [TIMER_W-1:0] count,
   output logic               expire
);

   logic [TIMER_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (tick && !(saturate && count_q == '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= RESET_VALUE;
      end else begin
         count_q <= count_d;
      end
   end

   assign count  = count_q;
   assign expire = tick && (count_q == TIMER_W'(1));

endmodule

// File: rtl/crosswalk_sequencer.sv
// rtl/crosswalk_sequencer.sv - mid-block crossing phase controller (vehicle lamps + ped phase)
// Optional AUDIBLE_CHIRP_EN adds a chirp output toggling per tick during WALK.
module crosswalk_sequencer
   import crosswalk_pkg::*;
#(
   parameter int GREEN_MIN   = 30,
   parameter int YELLOW_TIME = 4,
   parameter int ALL_RED     = 2,
   parameter int WALK_TIME   = 10,
   parameter int CLEAR_TIME  = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               ped_button,
   output logic               car_green,
   output logic               car_yellow,
   output logic               car_red,
   output logic               ped_enable,
   output logic [TIMER_W-1:0] master_timer,
`ifdef AUDIBLE_CHIRP_EN
   output logic               chirp,
`endif
   output logic               ped_wait
);

   localparam bit PARAMS_OK =
      (GREEN_MIN   >= 1) && (GREEN_MIN   <= 126) &&
      (YELLOW_TIME >= 1) && (YELLOW_TIME <= 126) &&
      (ALL_RED     >= 1) && (ALL_RED     <= 126) &&
      (WALK_TIME   >= 1) && (WALK_TIME   <= 126) &&
      (CLEAR_TIME  >= 1) && (CLEAR_TIME  <= 30);

   if (!PARAMS_OK) begin : g_param_check
      $error("crosswalk_sequencer: phase duration parameter out of range");
   end

   localparam logic [TIMER_W-1:0] GREEN_L  = TIMER_W'(GREEN_MIN);
   localparam logic [TIMER_W-1:0] YELLOW_L = TIMER_W'(YELLOW_TIME);
   localparam logic [TIMER_W-1:0] ALLRED_L = TIMER_W'(ALL_RED);
   localparam logic [TIMER_W-1:0] WALK_L   = TIMER_W'(WALK_TIME);
   localparam logic [TIMER_W-1:0] CLEAR_L  = TIMER_W'(CLEAR_TIME);

   state_t             state_q, state_d;
   logic               req_q, req_d;
   logic               load;
   logic [TIMER_W-1:0] load_value;
   logic [TIMER_W-1:0] count;
   logic               expire;

   phase_timer #(.RESET_VALUE(GREEN_L)) u_phase_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_value (load_value),
      .tick       (tick),
      .saturate   (state_q == ST_GREEN),
      .count      (count),
      .expire     (expire)
   );

   always_comb begin
      state_d    = state_q;
      load       = 1'b0;
      load_value = GREEN_L;
      req_d      = req_q;
      case (state_q)
         ST_GREEN: if (tick && count == '0 && req_q) begin
            state_d = ST_YELLOW;  load = 1'b1; load_value = YELLOW_L;
         end
         ST_YELLOW: if (expire) begin
            state_d = ST_RED_IN;  load = 1'b1; load_value = ALLRED_L;
         end
         ST_RED_IN: if (expire) begin
            state_d = ST_WALK;    load = 1'b1; load_value = WALK_L;
         end
         ST_WALK: if (expire) begin
            state_d = ST_CLEAR;   load = 1'b1; load_value = CLEAR_L;
         end
         ST_CLEAR: if (expire) begin
            state_d = ST_RED_OUT; load = 1'b1; load_value = ALLRED_L;
         end
         ST_RED_OUT: if (expire) begin
            state_d = ST_GREEN;   load = 1'b1; load_value = GREEN_L;
         end
         default: begin
            state_d = ST_GREEN;   load = 1'b1; load_value = GREEN_L;
         end
      endcase
      // Clearing on WALK entry wins over a press in that same cycle
      if (state_d == ST_WALK && state_q != ST_WALK) begin
         req_d = 1'b0;
      end else if (ped_button && state_q != ST_WALK) begin
         req_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_GREEN;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
      end
   end

`ifdef AUDIBLE_CHIRP_EN
   logic chirp_q, chirp_d;

   always_comb begin
      chirp_d = 1'b0;
      if (state_d == ST_WALK && state_q == ST_WALK) begin
         chirp_d = tick ? ~chirp_q : chirp_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         chirp_q <= 1'b0;
      end else begin
         chirp_q <= chirp_d;
      end
   end

   assign chirp = chirp_q;
`endif

   always_comb begin
      car_green    = (state_q == ST_GREEN);
      car_yellow   = (state_q == ST_YELLOW);
      car_red      = !(state_q == ST_GREEN || state_q == ST_YELLOW);
      ped_enable   = (state_q == ST_WALK);
      master_timer = (state_q == ST_CLEAR) ? count : BLANK_TIMER;
      ped_wait     = req_q;
   end

endmodule

// File: tb/tb_crosswalk_sequencer.sv
// tb/tb_crosswalk_sequencer.sv - randomized bench for crosswalk_sequencer against a phase/elapsed-tick model
// Checks chirp as well when built with AUDIBLE_CHIRP_EN.
module tb_crosswalk_sequencer;

   localparam int GREEN_MIN  = 30;
   localparam int CLEAR_TIME = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       ped_button;
   logic       car_green, car_yellow, car_red, ped_enable, ped_wait;
   logic [6:0] master_timer;
`ifdef AUDIBLE_CHIRP_EN
   logic       chirp;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Model: phase index 0..5 (green, yellow, red_in, walk, clear, red_out) and ticks elapsed in it
   int dur [6] = '{GREEN_MIN, 4, 2, 10, 20, 2};
   int m_ph  = 0;
   int m_e   = 0;
   int m_req = 0;

   crosswalk_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .ped_button   (ped_button),
      .car_green    (car_green),
      .car_yellow   (car_yellow),
      .car_red      (car_red),
      .ped_enable   (ped_enable),
      .master_timer (master_timer),
`ifdef AUDIBLE_CHIRP_EN
      .chirp        (chirp),
`endif
      .ped_wait     (ped_wait)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (phase %0d, elapsed %0d)", tag, obs, exp, m_ph, m_e);
      end
   endtask

   task automatic model_update(input logic t, input logic b, input logic r);
      int nph, ne;
      if (r) begin
         m_ph = 0; m_e = 0; m_req = 0;
      end else begin
         nph = m_ph;
         ne  = m_e;
         if (t) begin
            if (m_ph == 0) begin
               if (m_e >= GREEN_MIN && m_req != 0) begin
                  nph = 1; ne = 0;
               end else if (m_e < GREEN_MIN) begin
                  ne = m_e + 1;
               end
            end else if (m_e + 1 == dur[m_ph]) begin
               nph = (m_ph + 1) % 6; ne = 0;
            end else begin
               ne = m_e + 1;
            end
         end
         if (nph == 3 && m_ph != 3) m_req = 0;
         else if (b && m_ph != 3)   m_req = 1;
         m_ph = nph;
         m_e  = ne;
      end
   endtask

   task automatic compare_all();
      check("car_green",    car_green,    m_ph == 0);
      check("car_yellow",   car_yellow,   m_ph == 1);
      check("car_red",      car_red,      m_ph >= 2);
      check("lamp_onehot",  car_green + car_yellow + car_red, 1);
      check("ped_enable",   ped_enable,   m_ph == 3);
      check("master_timer", master_timer, (m_ph == 4) ? CLEAR_TIME - m_e : 127);
      check("ped_wait",     ped_wait,     m_req);
`ifdef AUDIBLE_CHIRP_EN
      check("chirp",        chirp,        (m_ph == 3) ? (m_e % 2) : 0);
`endif
   endtask

   task automatic step(input logic t, input logic b, input logic r);
      tick       = t;
      ped_button = b;
      reset      = r;
      @(posedge clk);
      model_update(t, b, r);
      #1;
      compare_all();
   endtask

   initial begin
      int reached;
      reset      = 1'b1;
      tick       = 1'b0;
      ped_button = 1'b0;
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);

      // idle: no requests, green must hold for 200 ticks
      for (int i = 0; i < 800; i++) step(i % 4 == 3, 1'b0, 1'b0);

      // single press shortly after tick 5, then one full pedestrian cycle
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 400; i++) step(i % 4 == 3, i == 21, 1'b0);

      for (int i = 0; i < 12000; i++) step(i % 4 == 3, $urandom_range(99) < 4, 1'b0);

      // reset mid-WALK, with a tick coinciding with reset
      reached = 0;
      for (int i = 0; i < 3000 && reached == 0; i++) begin
         step(i % 4 == 3, 1'b1, 1'b0);
         if (m_ph == 3 && m_e == 4) reached = 1;
      end
      check("walk_reached", reached, 1);
      step(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4000; i++) step(i % 4 == 3, $urandom_range(99) < 3, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
